// File: rtl/uart_pkg.sv
// Shared types and ASCII constants for the UART hex printer family.
// UART_HEX_PREFIX_EN adds the "0x" prefix states to the state encoding.
package uart_pkg;

`ifdef UART_HEX_PREFIX_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PFX0,
        ST_PFX1,
        ST_DIGIT,
        ST_CR,
        ST_LF
    } uart_hex_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_CR,
        ST_LF
    } uart_hex_state_t;
`endif

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_A  = 8'h41;

endpackage

// File: rtl/uart_hex_printer_if.sv
// Word-in / byte-out bus of the hex printer.
//
// Handshake: upstream holds word_valid with word_in stable; a word is
// accepted on a rising edge where word_valid && word_ready. Downstream
// a byte is written on every cycle wren is high; the printer never
// raises wren while full is high and keeps data_out stable while held.
interface uart_hex_printer_if #(
    parameter int NIBBLES = 8
);
    logic [4*NIBBLES-1:0] word_in;
    logic                 word_valid;
    logic                 word_ready;
    logic [7:0]           data_out;
    logic                 wren;
    logic                 full;

    // Environment side: supplies words and FIFO back-pressure.
    modport master (
        output word_in, word_valid, full,
        input  word_ready, data_out, wren
    );

    // Printer side.
    modport slave (
        input  word_in, word_valid, full,
        output word_ready, data_out, wren
    );
endinterface

// File: rtl/uart_nibble_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex character.
module uart_nibble_ascii
    import uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Digits map onto '0'..'9', letters onto 'A'..'F'.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_hex_printer.sv
// Prints each accepted word as NIBBLES uppercase hex digits plus CR LF,
// one byte per cycle into a UART TX FIFO write port.
// Defining UART_HEX_PREFIX_EN prepends "0x" to every line.
module uart_hex_printer
    import uart_pkg::*;
#(
    parameter int NIBBLES = 8
) (
    input  logic              CLK,
    input  logic              rst,
    uart_hex_printer_if.slave bus,
    output uart_hex_state_t   state_dbg
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NIBBLES - 1);

    uart_hex_state_t state;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic [7:0]      digit_ascii;
    logic [7:0]      data_c;
    logic            wr;

    uart_nibble_ascii u_nibble_ascii (
        .nibble (shreg[W-1 -: 4]),
        .ascii  (digit_ascii)
    );

    // A byte goes out whenever a line is in progress and the FIFO has room;
    // reset cuts the line off in the same cycle.
    assign wr             = !rst && (state != ST_IDLE) && !bus.full;
    assign bus.wren       = wr;
    assign bus.word_ready = !rst && (state == ST_IDLE);
    assign bus.data_out   = data_c;
    assign state_dbg      = state;

    // Character for the current state; stable while the FIFO is full.
    always_comb begin
        data_c = 8'h00;
        if (!rst) begin
            case (state)
`ifdef UART_HEX_PREFIX_EN
                ST_PFX0:  data_c = ASCII_0;
                ST_PFX1:  data_c = ASCII_X;
`endif
                ST_DIGIT: data_c = digit_ascii;
                ST_CR:    data_c = ASCII_CR;
                ST_LF:    data_c = ASCII_LF;
                default:  data_c = 8'h00;
            endcase
        end
    end

    // Line sequencer: advances only on cycles where a byte is written.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.word_valid) begin
                        shreg <= bus.word_in;
                        cnt   <= '0;
`ifdef UART_HEX_PREFIX_EN
                        state <= ST_PFX0;
`else
                        state <= ST_DIGIT;
`endif
                    end
                end
`ifdef UART_HEX_PREFIX_EN
                ST_PFX0: if (wr) state <= ST_PFX1;
                ST_PFX1: if (wr) state <= ST_DIGIT;
`endif
                ST_DIGIT: begin
                    if (wr) begin
                        // MSB nibble first: shift the next digit into the top.
                        shreg <= shreg << 4;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST_DIGIT) begin
                            state <= ST_CR;
                        end
                    end
                end
                ST_CR: if (wr) state <= ST_LF;
                ST_LF: if (wr) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_hex_printer.md
# uart_hex_printer

Formats binary words as uppercase ASCII hexadecimal lines and pushes them byte-by-byte into the UART transmit block's FIFO write port (`data_in`/`wren`/`full`). It sits directly upstream of the UART. It lets debug logic print register values over the serial line without a CPU. Each accepted word becomes `NIBBLES` hex characters followed by CR LF, optionally preceded by "0x".

## Interface
- `NIBBLES`, default 8: hex digits per word, legal range 1..8; word width is 4*NIBBLES.
- `CLK`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `word_in`  in  4*NIBBLES  word to print; sampled on accept.
- `word_valid`  in  1  upstream offers `word_in`.
- `word_ready`  out  1  block idle and able to accept; accept = `word_valid && word_ready` at a rising edge.
- `data_out`  out  8  ASCII byte to UART (`data_in` of UART).
- `wren`  out  1  write strobe to UART FIFO; one byte per cycle asserted.
- `full`  in  1  UART FIFO full; no write while high.

## Operation
- States: IDLE, PFX0, PFX1, DIGIT, CR, LF. PFX0/PFX1 exist only with `UART_HEX_PREFIX_EN`.
- IDLE:
  - `word_ready`=1 (0 while `rst` high).
  - On accept: load `word_in` into shift register, clear digit counter.
  - Next state is PFX0 when prefix is enabled, else DIGIT.
- Emitting states:
  - `wren` = (state != IDLE) && !`full`. Combinational.
  - `data_out` is combinational from the state and the top nibble of the shift register.
  - State and counter advance only on a cycle where `wren`=1. While `full`=1, hold state; `data_out` stays stable.
- Characters per state:
  - PFX0 emits 8'h30 ('0'); PFX1 emits 8'h78 ('x').
  - DIGIT emits the top nibble: 0–9 map to 8'h30–8'h39, A–F map to 8'h41–8'h46.
  - On each DIGIT write, shift left by 4 and increment the counter. After the NIBBLES-th digit, go to CR.
  - CR emits 8'h0D, then LF emits 8'h0A, then return to IDLE.
- Digit order is MSB nibble first. The counter is `$clog2(NIBBLES+1)` bits wide and never wraps past NIBBLES.
- `word_valid` is ignored outside IDLE. A word is never partially overwritten.
- Reset values: state IDLE, `wren`=0, `word_ready`=0 during reset, shift register and counter 0, `data_out`=8'h00.
- Reset mid-line: the line is abandoned immediately and no further bytes are written. The UART receives a truncated line, which is acceptable.

## Timing
- Accept at edge E. The first `wren` is in cycle E+1 if `full`=0.
- Bytes per word: L = NIBBLES+2, or NIBBLES+4 with prefix.
- With `full` held low, writes occupy L consecutive cycles. IDLE is re-entered the cycle after the LF write, so the period is L+1 cycles per word back-to-back.
- `full` rising in the same cycle as a pending write blocks that write; the byte is written on the first cycle `full` is low again. No byte is duplicated or dropped.
- `full` is assumed to reflect all prior writes by the following cycle. The UART FIFO guarantees this.

## Configuration
- `UART_HEX_PREFIX_EN` defined: every line is prefixed with "0x". L = NIBBLES+4.
- Not defined: PFX0/PFX1 are absent from the state encoding; lines are bare digits plus CR LF.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_hex_state_t`;
  - ASCII constants `ASCII_CR`, `ASCII_LF`, `ASCII_0`, `ASCII_X`, `ASCII_A`.
- One sub-module, `uart_nibble_ascii`: combinational 4-bit in, 8-bit uppercase ASCII out. It is reusable by other UART debug formatters.

## Test plan
- No prefix, NIBBLES=8, `full`=0, word 32'hDEADBEEF → bytes 44 45 41 44 42 45 45 46 0D 0A. `wren` high for 10 consecutive cycles starting E+1; `word_ready` returns at E+11.
- With `UART_HEX_PREFIX_EN`, word 32'h0000000A → 30 78 30 30 30 30 30 30 30 41 0D 0A (12 writes).
- `full` forced high for 5 cycles during the third digit of 32'h12345678 → `wren`=0 and `data_out`=8'h33 held throughout; output stream unchanged.
- `word_valid` held high continuously with words 32'h1 then 32'h2 → two complete lines, accepts exactly L+1 cycles apart; a word changed mid-line is not accepted.
- `rst` pulsed for 1 cycle after the 4th byte of a line → no `wren` from the reset cycle until a new accept; the next word prints in full.
- NIBBLES=1, word 4'hF → 46 0D 0A; the counter terminates correctly at the boundary.
